stopwatch_ctrl: RTL and testbench

- Stopwatch control and counting stage. It sits between the frequency divider and the BCD-to-7-segment decoder of the board-level top.
- Consumes a 1-cycle tick (one per 0.1 s) and two raw push-button levels.
- Maintains a 00.0–99.9 s BCD count under a start/pause/lap/clear state machine.
- Drives three BCD digits plus a status flag to the display decoder.

---
 rtl/stopwatch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and counting stage: start/pause/lap/clear FSM over a
// 00.0-99.9 s BCD count, feeding three digits to the 7-segment decoder.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   tick       1-cycle count enable, one per 0.1 s
//   btn_start  raw start/stop level (asynchronous)
//   btn_lap    raw lap/clear level (asynchronous)
//   dig2..dig0 displayed BCD digits (tens, seconds, tenths)
//   dpt        decimal points, constant 3'b010
//   running    high in RUN or LAP
//   lap_view   high in LAP (display frozen on lap register)
//   ovf        sticky saturation flag (WRAP=0 only)
module stopwatch_ctrl #(
  parameter int WRAP     = 1,
  parameter int MAX_TENS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [2:0] dpt,
  output logic       running,
  output logic       lap_view,
  output logic       ovf
);

  localparam logic [3:0] LP_MAX = 4'(MAX_TENS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE
  } state_t;

  state_t     r_state;
  logic [1:0] r_s1, r_s2, r_s3;
  logic [1:0] r_vld;
  logic [1:0] r_arm;
  logic [3:0] r_d2, r_d1, r_d0;
  logic [3:0] r_l2, r_l1, r_l0;
  logic       r_run;
  logic       r_lapv;
  logic       r_ovf;

  logic [1:0] w_btn;
  logic [1:0] w_press;
  logic       w_start;
  logic       w_lap;
  logic       w_cnt;
  logic       w_term;
  logic [3:0] w_n2, w_n1, w_n0;

  // Bit 0 = start, bit 1 = lap.
  assign w_btn = {btn_lap, btn_start};

  // r_vld[1] marks that s2 now holds a genuinely sampled level. A button
  // only arms once s2 has been seen low, so a button held across reset
  // release cannot produce a press until it is released and pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_vld <= '0;
      r_arm <= '0;
    end else begin
      r_s1  <= w_btn;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_vld <= {r_vld[0], 1'b1};
      r_arm <= r_arm | ({2{r_vld[1]}} & ~r_s2);
    end
  end

  assign w_press = r_s2 & ~r_s3 & r_arm;
  assign w_start = w_press[0];
  assign w_lap   = w_press[1];

  assign w_cnt  = tick & ((r_state == S_RUN) | (r_state == S_LAP));
  assign w_term = (r_d2 == LP_MAX) & (r_d1 == 4'd9) & (r_d0 == 4'd9);

  // BCD increment; terminal count rolls to 000 (used only when WRAP=1).
  always_comb begin
    w_n2 = r_d2;
    w_n1 = r_d1;
    w_n0 = r_d0 + 4'd1;
    if (r_d0 == 4'd9) begin
      w_n0 = 4'd0;
      w_n1 = r_d1 + 4'd1;
      if (r_d1 == 4'd9) begin
        w_n1 = 4'd0;
        w_n2 = r_d2 + 4'd1;
      end
    end
    if (w_term) begin
      w_n2 = 4'd0;
      w_n1 = 4'd0;
      w_n0 = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_d2    <= '0;
      r_d1    <= '0;
      r_d0    <= '0;
      r_l2    <= '0;
      r_l1    <= '0;
      r_l0    <= '0;
      r_run   <= 1'b0;
      r_lapv  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_cnt) begin
        if (w_term && (WRAP == 0)) begin
          r_ovf <= 1'b1;
        end else begin
          r_d2 <= w_n2;
          r_d1 <= w_n1;
          r_d0 <= w_n0;
        end
      end
      // start has priority; a lap in the same cycle is dropped.
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_start) begin
            r_state <= S_PAUSE;
            r_run   <= 1'b0;
          end else if (w_lap) begin
            r_state <= S_LAP;
            r_lapv  <= 1'b1;
            r_l2    <= r_d2;
            r_l1    <= r_d1;
            r_l0    <= r_d0;
          end
        end
        S_LAP: begin
          if (w_start) begin
            r_state <= S_PAUSE;
            r_run   <= 1'b0;
            r_lapv  <= 1'b0;
          end else if (w_lap) begin
            r_state <= S_RUN;
            r_lapv  <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end else if (w_lap) begin
            r_state <= S_IDLE;
            r_d2    <= '0;
            r_d1    <= '0;
            r_d0    <= '0;
            r_ovf   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dig2     = r_lapv ? r_l2 : r_d2;
  assign dig1     = r_lapv ? r_l1 : r_d1;
  assign dig0     = r_lapv ? r_l0 : r_d0;
  assign dpt      = 3'b010;
  assign running  = r_run;
  assign lap_view = r_lapv;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: three instances (wrap/9, saturate/9, wrap/5),
// expected outputs queued at stimulus time and compared when sampled.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tk [3];
  logic       bs [3];
  logic       bl [3];
  logic [3:0] d2 [3];
  logic [3:0] d1 [3];
  logic [3:0] d0 [3];
  logic [2:0] dp [3];
  logic       run[3];
  logic       lv [3];
  logic       ov [3];

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int          d;
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.WRAP(1), .MAX_TENS(9)) u0 (
    .clk(clk), .rst(rst), .tick(tk[0]),
    .btn_start(bs[0]), .btn_lap(bl[0]),
    .dig2(d2[0]), .dig1(d1[0]), .dig0(d0[0]),
    .dpt(dp[0]), .running(run[0]),
    .lap_view(lv[0]), .ovf(ov[0])
  );

  stopwatch_ctrl #(.WRAP(0), .MAX_TENS(9)) u1 (
    .clk(clk), .rst(rst), .tick(tk[1]),
    .btn_start(bs[1]), .btn_lap(bl[1]),
    .dig2(d2[1]), .dig1(d1[1]), .dig0(d0[1]),
    .dpt(dp[1]), .running(run[1]),
    .lap_view(lv[1]), .ovf(ov[1])
  );

  stopwatch_ctrl #(.WRAP(1), .MAX_TENS(5)) u2 (
    .clk(clk), .rst(rst), .tick(tk[2]),
    .btn_start(bs[2]), .btn_lap(bl[2]),
    .dig2(d2[2]), .dig1(d1[2]), .dig0(d0[2]),
    .dpt(dp[2]), .running(run[2]),
    .lap_view(lv[2]), .ovf(ov[2])
  );

  function automatic logic [17:0] obs(int d);
    return {dp[d], run[d], lv[d], ov[d], d2[d], d1[d], d0[d]};
  endfunction

  function automatic logic [17:0] ex(
    bit r, bit l, bit o, int a, int b, int c);
    return {3'b010, r, l, o, 4'(a), 4'(b), 4'(c)};
  endfunction

  task automatic chk(string tag, logic [17:0] got, logic [17:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic push(int d, string tag, logic [17:0] v);
    exp_t e;
    e.d = d;
    e.tag = tag;
    e.v = v;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, obs(e.d), e.v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick_n(int d, int n);
    tk[d] = 1'b1;
    repeat (n) @(negedge clk);
    tk[d] = 1'b0;
  endtask

  // Button rises before edge k; FSM acts at k+2. Optional tick in the
  // cycle ending at k+2. Ends on the negedge right after k+2.
  task automatic press(int d, bit s, bit l, bit t);
    bs[d] = s;
    bl[d] = l;
    @(negedge clk);
    @(negedge clk);
    tk[d] = t;
    @(negedge clk);
    tk[d] = 1'b0;
    bs[d] = 1'b0;
    bl[d] = 1'b0;
  endtask

  task automatic gap();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tk[i] = 1'b0;
      bs[i] = 1'b0;
      bl[i] = 1'b0;
    end
    do_reset();
    push(0, "rst_u0", ex(0, 0, 0, 0, 0, 0));
    push(1, "rst_u1", ex(0, 0, 0, 0, 0, 0));
    push(2, "rst_u2", ex(0, 0, 0, 0, 0, 0));
    sb_check();

    // start, 25 ticks, stop with coincident tick
    push(0, "start", ex(1, 0, 0, 0, 0, 0));
    press(0, 1, 0, 0);
    sb_check();
    gap();
    push(0, "t25", ex(1, 0, 0, 0, 2, 5));
    tick_n(0, 25);
    sb_check();
    push(0, "stop_tick", ex(0, 0, 0, 0, 2, 6));
    press(0, 1, 0, 1);
    sb_check();
    gap();
    push(0, "pause_noct", ex(0, 0, 0, 0, 2, 6));
    tick_n(0, 5);
    sb_check();
    push(0, "clear", ex(0, 0, 0, 0, 0, 0));
    press(0, 0, 1, 0);
    sb_check();
    gap();
    push(0, "idle_lap", ex(0, 0, 0, 0, 0, 0));
    press(0, 0, 1, 0);
    sb_check();
    gap();

    // lap freeze
    do_reset();
    press(0, 1, 0, 0);
    gap();
    push(0, "t123", ex(1, 0, 0, 1, 2, 3));
    tick_n(0, 123);
    sb_check();
    push(0, "lap_in", ex(1, 1, 0, 1, 2, 3));
    press(0, 0, 1, 0);
    sb_check();
    gap();
    push(0, "lap_frz", ex(1, 1, 0, 1, 2, 3));
    tick_n(0, 20);
    sb_check();
    push(0, "lap_out", ex(1, 0, 0, 1, 4, 3));
    press(0, 0, 1, 0);
    sb_check();
    gap();
    push(0, "lap_pre", ex(1, 1, 0, 1, 4, 3));
    press(0, 0, 1, 1);
    sb_check();
    gap();
    push(0, "lap_out2", ex(1, 0, 0, 1, 4, 4));
    press(0, 0, 1, 0);
    sb_check();
    gap();
    push(0, "both", ex(0, 0, 0, 1, 4, 4));
    press(0, 1, 1, 0);
    sb_check();
    gap();
    push(0, "resume", ex(1, 0, 0, 1, 4, 4));
    press(0, 1, 0, 0);
    sb_check();
    gap();

    // terminal count behaviour
    do_reset();
    press(0, 1, 0, 0);
    gap();
    push(0, "w_999", ex(1, 0, 0, 9, 9, 9));
    tick_n(0, 999);
    sb_check();
    push(0, "w_wrap", ex(1, 0, 0, 0, 0, 0));
    tick_n(0, 1);
    sb_check();
    push(0, "w_post", ex(1, 0, 0, 0, 0, 7));
    tick_n(0, 7);
    sb_check();

    press(1, 1, 0, 0);
    gap();
    push(1, "s_999", ex(1, 0, 0, 9, 9, 9));
    tick_n(1, 999);
    sb_check();
    push(1, "s_hold", ex(1, 0, 1, 9, 9, 9));
    tick_n(1, 1);
    sb_check();
    push(1, "s_hold2", ex(1, 0, 1, 9, 9, 9));
    tick_n(1, 3);
    sb_check();
    push(1, "s_pause", ex(0, 0, 1, 9, 9, 9));
    press(1, 1, 0, 0);
    sb_check();
    gap();
    push(1, "s_clear", ex(0, 0, 0, 0, 0, 0));
    press(1, 0, 1, 0);
    sb_check();
    gap();

    press(2, 1, 0, 0);
    gap();
    push(2, "m5_599", ex(1, 0, 0, 5, 9, 9));
    tick_n(2, 599);
    sb_check();
    push(2, "m5_wrap", ex(1, 0, 0, 0, 0, 0));
    tick_n(2, 1);
    sb_check();

    // press acts exactly once, two edges after the first sampling edge
    do_reset();
    bs[0] = 1'b1;
    @(negedge clk);
    push(0, "bt_k", ex(0, 0, 0, 0, 0, 0));
    sb_check();
    @(negedge clk);
    push(0, "bt_k1", ex(0, 0, 0, 0, 0, 0));
    sb_check();
    @(negedge clk);
    push(0, "bt_k2", ex(1, 0, 0, 0, 0, 0));
    sb_check();
    repeat (47) @(negedge clk);
    push(0, "bt_hold", ex(1, 0, 0, 0, 0, 0));
    sb_check();
    bs[0] = 1'b0;
    gap();

    // asynchronous reset mid-run
    push(0, "r_456", ex(1, 0, 0, 4, 5, 6));
    tick_n(0, 456);
    sb_check();
    #2 rst = 1'b1;
    #1;
    push(0, "r_async", ex(0, 0, 0, 0, 0, 0));
    sb_check();
    @(negedge clk);
    rst = 1'b0;
    gap();

    // button held through reset release
    bs[0] = 1'b1;
    do_reset();
    repeat (10) @(negedge clk);
    push(0, "held_rst", ex(0, 0, 0, 0, 0, 0));
    sb_check();
    bs[0] = 1'b0;
    gap();
    push(0, "repress", ex(1, 0, 0, 0, 0, 0));
    press(0, 1, 0, 0);
    sb_check();
    gap();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
